// File: rtl/tff_pkg.sv
// tff_pkg: mode encoding and modulus limit helper shared by the tff_counter slice
package tff_pkg;
  typedef enum logic [1:0] {TOGGLE = 2'b00, UP = 2'b01, DOWN = 2'b10, LOAD = 2'b11} mode_t;
  // Largest legal count; computed in 64 bits so MODULUS = 2**32 does not overflow
  function automatic logic [31:0] mod_limit(input longint modulus);
    return 32'(modulus - 64'sd1);
  endfunction
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with asynchronous active-low reset
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic qbar
);
  logic q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= 1'b0;
    else q_q <= q_q ^ t;
  assign q = q_q;
  assign qbar = ~q_q;
endmodule

// File: rtl/tff_counter.sv
// tff_counter: WIDTH T-cells driven by a mode-selected next-state engine
module tff_counter
  import tff_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_vec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LIM   = WIDTH'(mod_limit(MODULUS));
  localparam logic [WIDTH:0]   LIM_X = {1'b0, LIM};
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  logic [WIDTH-1:0] state_q, nxt_d, t;
  logic at_top, over, ld_over, wrap_q;
  // Compare one bit wider so a full-range modulus never folds to a constant
  assign at_top  = {1'b0, state_q} >= LIM_X;
  assign over    = {1'b0, state_q} > LIM_X;
  assign ld_over = {1'b0, load_val} > LIM_X;
  always_comb begin
    nxt_d = state_q;
    case (mode)
      TOGGLE:  nxt_d = state_q ^ t_vec;
      UP:      nxt_d = at_top ? '0 : state_q + ONE;
      DOWN:    nxt_d = (state_q == '0 || over) ? LIM : state_q - ONE;
      LOAD:    nxt_d = ld_over ? LIM : load_val;
      default: nxt_d = state_q;
    endcase
  end
  assign t  = en ? state_q ^ nxt_d : '0;
  assign tc = en & ((mode == UP & at_top) | (mode == DOWN & (state_q == '0 | over)));
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (.clk(clk), .rst_n(rst_n), .t(t[i]), .q(state_q[i]), .qbar(qbar[i]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap_q <= 1'b0;
    else wrap_q <= tc;
  assign q = state_q;
  assign wrap = wrap_q;
endmodule
